// File: rtl/elastic_pipe_pkg.sv
// elastic_pipe_pkg: definitions shared by the elastic pipeline files.
//   WORD           default payload width
//   CYCLE          nominal clock period used by benches
//   PIPE_MAX_DEPTH largest legal stage count
//   xfer_e         encoding of {input transfer, output transfer} per cycle
//   occ_width()    width of an occupancy counter able to hold 0..2*depth
package elastic_pipe_pkg;

    localparam int WORD           = 32;
    localparam int CYCLE          = 10;
    localparam int PIPE_MAX_DEPTH = 16;

    typedef enum logic [1:0] {
        XFER_NONE = 2'b00,
        XFER_OUT  = 2'b01,
        XFER_IN   = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

    // Sized for the skid build so both builds share one port width.
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one elastic register stage with valid/ready on both sides.
// Build option: ELASTIC_PIPE_SKID_EN turns the stage into a two-entry skid
// buffer whose upstream ready comes from a register; without it the stage is
// a single register and its ready is formed by the parent from the chain.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   run                   0 freezes every register in the stage
//   flush                 synchronous discard of the stage contents
//   up_valid, up_data     payload offered by the predecessor
//   up_ready              (skid build only) stage can take a payload
//   dn_valid, dn_data     payload held by the stage
//   dn_ready              successor takes the payload this cycle
module pipe_stage
    import elastic_pipe_pkg::*;
#(
    parameter int WIDTH = WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
`ifdef ELASTIC_PIPE_SKID_EN
    output logic             up_ready,
`endif
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    input  logic             dn_ready
);

`ifdef ELASTIC_PIPE_SKID_EN

    logic             main_v_r, skid_v_r, ready_r;
    logic [WIDTH-1:0] main_d_r, skid_d_r;
    logic             main_v_s, skid_v_s;
    logic [WIDTH-1:0] main_d_s, skid_d_s;
    logic             adv_s, take_s, give_s;

    // Handshake qualifiers; ready_r is always the inverse of skid_v_r.
    always_comb begin
        adv_s    = run & ~flush;
        take_s   = up_valid & ready_r & adv_s;
        give_s   = main_v_r & dn_ready & adv_s;
        up_ready = ready_r & adv_s;
    end

    // Next contents: main feeds the output, skid catches a payload that
    // arrives while main is stalled.
    always_comb begin
        main_v_s = main_v_r;
        main_d_s = main_d_r;
        skid_v_s = skid_v_r;
        skid_d_s = skid_d_r;
        if (!run) begin
            main_v_s = main_v_r;
        end else if (flush) begin
            main_v_s = 1'b0;
            skid_v_s = 1'b0;
        end else if (give_s) begin
            if (skid_v_r) begin
                // ready_r was low, so no new payload arrives this cycle.
                main_v_s = 1'b1;
                main_d_s = skid_d_r;
                skid_v_s = 1'b0;
            end else begin
                main_v_s = take_s;
                main_d_s = take_s ? up_data : main_d_r;
            end
        end else if (take_s) begin
            if (main_v_r) begin
                skid_v_s = 1'b1;
                skid_d_s = up_data;
            end else begin
                main_v_s = 1'b1;
                main_d_s = up_data;
            end
        end else begin
            main_v_s = main_v_r;
        end
    end

    // Stage registers, including the registered upstream ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_v_r <= 1'b0;
            main_d_r <= {WIDTH{1'b0}};
            skid_v_r <= 1'b0;
            skid_d_r <= {WIDTH{1'b0}};
            ready_r  <= 1'b1;
        end else begin
            main_v_r <= main_v_s;
            main_d_r <= main_d_s;
            skid_v_r <= skid_v_s;
            skid_d_r <= skid_d_s;
            ready_r  <= ~skid_v_s;
        end
    end

    assign dn_valid = main_v_r;
    assign dn_data  = main_d_r;

`else

    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic             room_s;

    // The stage can load when empty or when its payload leaves this cycle.
    always_comb begin
        room_s = run & ~flush & (~valid_r | dn_ready);
    end

    // Single stage register; a frozen pipe holds everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
        end else if (!run) begin
            valid_r <= valid_r;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (room_s) begin
            valid_r <= up_valid;
            if (up_valid) begin
                data_r <= up_data;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    assign dn_valid = valid_r;
    assign dn_data  = data_r;

`endif

endmodule

// File: rtl/elastic_pipe.sv
// elastic_pipe: DEPTH elastic register stages with run/freeze, synchronous
// flush, per-stage back-pressure and an occupancy counter.
// Build option: ELASTIC_PIPE_SKID_EN gives two-entry skid stages (capacity
// 2*DEPTH, registered ready); default capacity is DEPTH with a combinational
// ready chain from out_ready to in_ready.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   run                            0 freezes all state and forces in_ready=0
//   flush                          synchronous discard of every stage
//   in_valid, in_ready, in_data    upstream handshake and payload
//   out_valid, out_ready, out_data downstream handshake and payload
//   occupancy                      number of payloads held
module elastic_pipe
    import elastic_pipe_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int DEPTH = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        run,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [occ_width(DEPTH)-1:0] occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    if ((DEPTH < 1) || (DEPTH > PIPE_MAX_DEPTH)) begin : g_depth_check
        $error("elastic_pipe: DEPTH outside 1..PIPE_MAX_DEPTH");
    end

    // Index i is the input side of stage i; index DEPTH is the pipe output.
    logic [DEPTH:0]            vld_s;
    logic [DEPTH:0]            rdy_s;
    logic [DEPTH:0][WIDTH-1:0] dat_s;
    logic                      adv_s, in_xfer_s, out_xfer_s;
    xfer_e                     xfer_s;
    logic [OCC_W-1:0]          occ_r;

    assign vld_s[0] = in_valid;
    assign dat_s[0] = in_data;

`ifdef ELASTIC_PIPE_SKID_EN
    assign rdy_s[DEPTH] = out_ready;
`else
    // Ready chain: stage i accepts when it or any later stage has a hole,
    // or the output drains this cycle.
    always_comb begin
        rdy_s[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy_s[i] = adv_s & (~vld_s[i+1] | rdy_s[i+1]);
        end
    end
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .run      (run),
            .flush    (flush),
            .up_valid (vld_s[g]),
            .up_data  (dat_s[g]),
`ifdef ELASTIC_PIPE_SKID_EN
            .up_ready (rdy_s[g]),
`endif
            .dn_valid (vld_s[g+1]),
            .dn_data  (dat_s[g+1]),
            .dn_ready (rdy_s[g+1])
        );
    end

    // Transfer qualifiers; a flush cycle counts no handshake at either end.
    always_comb begin
        adv_s      = run & ~flush;
        in_ready   = rdy_s[0] & adv_s & ~reset;
        in_xfer_s  = in_valid & in_ready;
        out_xfer_s = vld_s[DEPTH] & out_ready & adv_s;
        xfer_s     = xfer_e'({in_xfer_s, out_xfer_s});
    end

    // Occupancy counter tracking accepted minus delivered payloads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_r <= {OCC_W{1'b0}};
        end else if (!run) begin
            occ_r <= occ_r;
        end else if (flush) begin
            occ_r <= {OCC_W{1'b0}};
        end else begin
            case (xfer_s)
                XFER_IN:  occ_r <= occ_r + OCC_W'(1'b1);
                XFER_OUT: occ_r <= occ_r - OCC_W'(1'b1);
                default:  occ_r <= occ_r;
            endcase
        end
    end

    assign out_valid = vld_s[DEPTH];
    assign out_data  = dat_s[DEPTH];
    assign occupancy = occ_r;

endmodule

// File: tb/tb_elastic_pipe.sv
// tb_elastic_pipe: randomized and directed stimulus for elastic_pipe
// (WIDTH=32, DEPTH=5) checked against a queue model of the pipe contents.
module tb_elastic_pipe;
    import elastic_pipe_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 5;
    localparam int OCC_W = occ_width(DEPTH);
`ifdef ELASTIC_PIPE_SKID_EN
    localparam int CAP = 2 * DEPTH;
`else
    localparam int CAP = DEPTH;
`endif

    logic             clk = 1'b0;
    logic             reset, run, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    logic [OCC_W-1:0] occupancy;

    elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #(CYCLE / 2) clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          acc;
    } ent_t;

    ent_t q[$];
    int   n_vec = 0, n_miss = 0;
    int   cyc = 0, n_acc = 0, first_acc = -1, first_ov = -1, last_out = -1, peak = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, let the
    // edge happen, then update the model with the transfers that occurred.
    task automatic tick(input logic v, input logic [31:0] d, input logic ordy,
                        input logic r, input logic f);
        logic exp_rdy, ixf, oxf;
        in_valid = v; in_data = d; out_ready = ordy; run = r; flush = f;
        #1;
        chk("occupancy", 32'(occupancy), q.size());
`ifdef ELASTIC_PIPE_SKID_EN
        exp_rdy = r & ~f & (q.size() < CAP);
        chk("in_ready_cap", {31'd0, in_ready & ~exp_rdy}, 32'd0);
`else
        exp_rdy = r & ~f & ((q.size() < CAP) | ordy);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
`endif
        if (q.size() == 0) begin
            chk("out_valid_empty", {31'd0, out_valid}, 32'd0);
        end else if (out_valid) begin
            chk("out_data", out_data, q[0].data);
            chk("too_early", {31'd0, (cyc - q[0].acc) >= DEPTH}, 32'd1);
        end
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (int'(occupancy) > peak) peak = int'(occupancy);
        ixf = v & in_ready;
        oxf = out_valid & ordy & r & ~f;
        @(posedge clk);
        if (r) begin
            if (f) begin
                q.delete();
            end else begin
                if (oxf) begin
                    if (q.size() > 0) void'(q.pop_front());
                    last_out = cyc;
                end
                if (ixf) begin
                    q.push_back('{data: d, acc: cyc});
                    n_acc++;
                    if (first_acc < 0) first_acc = cyc;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && q.size() > 0; i++) tick(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        chk(tag, q.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fill: 0x1..0xA back to back with out_ready held high.
        n_acc = 0; first_acc = -1; first_ov = -1; peak = 0;
        for (int i = 0; i < 30 && n_acc < 10; i++) tick(1'b1, 32'(n_acc + 1), 1'b1, 1'b1, 1'b0);
        drain("fill_drain");
        chk("fill_accepts", n_acc, 32'd10);
        chk("fill_latency", first_ov - first_acc, DEPTH);
        chk("fill_nogap", last_out - first_ov, 32'd9);
        chk("fill_peak", peak, DEPTH);

        // Back-pressure: offer 12+ payloads with the output stalled.
        n_acc = 0;
        for (int i = 0; i < 20; i++) tick(1'b1, 32'h100 + 32'(n_acc), 1'b0, 1'b1, 1'b0);
        chk("bp_accepts", n_acc, CAP);
        drain("bp_drain");

        // Run freeze with three payloads in flight and the head at the output.
        n_acc = 0;
        for (int i = 0; i < 3; i++) tick(1'b1, 32'h200 + 32'(n_acc), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH - 3; i++) tick(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 32'h2FF, 1'b1, 1'b0, 1'b1);
            chk("frz_out_valid", {31'd0, out_valid}, 32'd1);
        end
        drain("frz_drain");

        // Flush with an input offered in the same cycle.
        for (int i = 0; i < 4; i++) tick(1'b1, 32'h300 + 32'(i), 1'b0, 1'b1, 1'b0);
        tick(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_occupancy", 32'(occupancy), 32'd0);
        for (int i = 0; i < 8; i++) tick(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset between edges with three entries held.
        for (int i = 0; i < 3; i++) tick(1'b1, 32'h400 + 32'(i), 1'b0, 1'b1, 1'b0);
        chk("arst_pre_occ", 32'(occupancy), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_occupancy", 32'(occupancy), 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        first_acc = -1; first_ov = -1;
        tick(1'b1, 32'h500, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        chk("arst_latency", first_ov - first_acc, DEPTH);
        chk("arst_empty", q.size(), 32'd0);

        // Random stress including freezes, flushes and frozen flushes.
        for (int i = 0; i < 10000; i++) begin
            tick($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) != 0, $urandom_range(0, 63) == 0);
        end
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/elastic_pipe.md
# elastic_pipe

Parametrised elastic pipeline of DEPTH register stages carrying WIDTH-bit payloads with a valid/ready handshake at each end. It adds run/freeze, synchronous flush and per-stage back-pressure, which the fixed five-stage datapath lacks. It is the building block for the next processor generation's inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the `clk & run` clock gating with a proper enable.

## Interface
- WIDTH, default `WORD` (32): payload width in bits.
- DEPTH, default 5: number of register stages; legal range 1..16.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  1 = pipeline advances; 0 = all state frozen, in_ready=0, out_valid held.
- flush  in  1  synchronous; discards every stage's contents.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  pipeline accepts the payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage DEPTH-1 holds a payload.
- out_ready  in  1  downstream consumes the payload this cycle.
- out_data  out  WIDTH  payload of the final stage.
- occupancy  out  $clog2(2*DEPTH+1)  number of valid entries held.

## Operation
- Transfer at input: in_valid & in_ready at a rising edge. Transfer at output: out_valid & out_ready & run.
- Each stage holds valid plus data. A stage loads from its predecessor when it is empty or its own payload leaves the same cycle.
- Payload order is strictly preserved. No payload is duplicated or dropped except by flush.
- run=0: no stage changes state, and occupancy is held. in_ready is forced 0. out_valid and out_data keep their values. A downstream out_ready is ignored.
- flush=1 (with run=1): all valid bits clear at the edge and occupancy goes to 0. in_ready=0 that cycle, so the input is not taken. Any out_ready handshake that cycle does not count as a transfer.
- flush with run=0: the flush is ignored; run gates everything.
- occupancy: increments on an input transfer and decrements on an output transfer. It is unchanged when both happen together.
- Data registers of empty stages are don't-care. out_data is only meaningful while out_valid=1.

## Timing
- Reset values: in_ready=0 during reset, then 1 from the first cycle after deassertion when run=1. out_valid=0, out_data=0, occupancy=0. All stage valid bits are 0.
- Reset asserted mid-operation discards all payloads immediately, without waiting for a clock edge.
- Latency: a payload accepted at edge N is presented on out_valid after edge N+DEPTH, provided there is no back-pressure.
- Throughput: one payload per cycle with out_ready held at 1.
- Full condition: occupancy equals the capacity, and in_ready=0 unless an output transfer occurs that cycle.
- Empty condition: out_valid=0 and occupancy=0.

## Configuration
- Macro ELASTIC_PIPE_SKID_EN.
- When defined:
  - Each stage is a two-entry skid buffer, and capacity is 2*DEPTH.
  - Every stage's ready output is a register, so there is no combinational path from out_ready to in_ready.
  - in_ready depends only on stage-0 state, run and flush.
- When undefined:
  - Capacity is DEPTH.
  - The ready of stage i is !valid_i | ready_{i+1}, which forms a combinational chain from out_ready to in_ready.
  - Latency and ordering are identical in both builds.

## Structure
- Shared header definitions.vh supplies `WORD` and `CYCLE`.
- Add `PIPE_MAX_DEPTH` (16) to the shared header and check DEPTH against it at elaboration.
- There is one sub-module, pipe_stage: one stage with valid/ready on both sides, run and flush. It contains the skid logic under ELASTIC_PIPE_SKID_EN.
- elastic_pipe instantiates DEPTH pipe_stage instances in a generate loop and maintains the occupancy counter.

## Test plan
- Reset and fill:
  - Setup: WIDTH=32, DEPTH=5, out_ready=1. Drive 0x1..0xA on consecutive cycles.
  - Expect: out_valid rises 5 cycles after the first accept. Outputs are 0x1..0xA with no gaps. occupancy peaks at 5.
- Back-pressure:
  - Setup: out_ready=0 while 12 payloads are offered.
  - Expect: in_ready drops after 5 accepts (10 with SKID_EN). Releasing out_ready yields all accepted payloads in order, none lost.
- Run freeze:
  - Setup: 3 payloads in flight, run=0 for 4 cycles with out_ready=1.
  - Expect: out_valid, out_data and occupancy are unchanged and no transfer occurs. Resuming completes the sequence in order.
- Flush:
  - Setup: pipe holds 4 entries. Assert flush together with in_valid=1 and in_data=0xDEAD.
  - Expect: next cycle out_valid=0 and occupancy=0. 0xDEAD is never output.
- Async reset mid-stream:
  - Setup: assert reset between clock edges while occupancy=3.
  - Expect: out_valid=0 and occupancy=0 before the next edge. Data sent after release arrives with the standard 5-cycle latency.
- Random stress:
  - Setup: random in_valid and out_ready for 10k cycles.
  - Expect: a scoreboard sees ordered, lossless delivery. occupancy equals the scoreboard count every cycle.
